// File: rtl/eth_rx_mailbox.sv
// eth_rx_mailbox: producer end of the CPU Ethernet receive mailbox.
// Captures MAC receive frames into two ping-pong banks and presents the oldest
// complete frame to the CPU. Optional macro ETH_RX_MBOX_DROP_CNT_EN adds the
// saturating drop_cnt output.
//
// Handshake: rx_* bytes are accepted on every cycle rx_valid is high (no
// backpressure). On the CPU side, eth_rx_ready (level) means a frame is
// presented; a 0->1 edge of eth_rx_read while ready releases that bank, and
// eth_rx_rdata returns the byte at eth_rx_raddr one cycle later.
module eth_rx_mailbox #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int MIN_LEN = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_sof,
    input  logic              rx_eof,
    input  logic              rx_err,
    output logic              eth_rx_ready,
    input  logic              eth_rx_read,
    input  logic [ADDR_W-1:0] eth_rx_raddr,
    output logic [7:0]        eth_rx_rdata,
    output logic [ADDR_W:0]   eth_rx_len,
    output logic              eth_rx_trunc,
`ifdef ETH_RX_MBOX_DROP_CNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic [1:0]        o_dbg_state,
    output logic              o_dbg_drop
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] MIN_C   = (ADDR_W + 1)'(MIN_LEN);

    state_t            r_state;
    logic [ADDR_W:0]   r_wcnt;
    logic              r_wtrunc;
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W:0]   r_len [2];
    logic [1:0]        r_trunc;
    logic              r_read_d;
    logic [7:0]        r_rdata;
    logic [7:0]        r_mem [2*DEPTH];

    state_t            w_next_state;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W:0]   w_cnt;
    logic              w_trunc;
    logic              w_eof_eval;
    logic              w_commit;
    logic              w_drop;
    logic              w_rel;

    // Write FSM: next state, RAM write, and end-of-frame commit/drop decision
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_cnt        = r_wcnt;
        w_trunc      = r_wtrunc;
        w_eof_eval   = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE, S_DISCARD: begin
                if (rx_valid) begin
                    if (rx_sof) begin
                        if (!r_full[r_wr_bank]) begin
                            w_we         = 1'b1;
                            w_cnt        = (ADDR_W + 1)'(1);
                            w_trunc      = 1'b0;
                            w_eof_eval   = rx_eof;
                            w_next_state = rx_eof ? S_IDLE : S_CAPTURE;
                        end else begin
                            // Both banks occupied: this frame is lost.
                            w_drop       = 1'b1;
                            w_next_state = rx_eof ? S_IDLE : S_DISCARD;
                        end
                    end else if (r_state == S_DISCARD && rx_eof) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_CAPTURE: begin
                if (rx_valid) begin
                    if (rx_sof) begin
                        // A new sof abandons the frame in progress silently.
                        w_we    = 1'b1;
                        w_cnt   = (ADDR_W + 1)'(1);
                        w_trunc = 1'b0;
                    end else if (r_wcnt < DEPTH_C) begin
                        w_we    = 1'b1;
                        w_waddr = r_wcnt[ADDR_W-1:0];
                        w_cnt   = r_wcnt + 1'b1;
                    end else begin
                        w_trunc = 1'b1;
                    end
                    if (rx_eof) begin
                        w_eof_eval   = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_eof_eval) begin
            if (rx_err || (w_cnt < MIN_C)) begin
                w_drop = 1'b1;
            end else begin
                w_commit = 1'b1;
            end
        end
    end

    assign w_rel = eth_rx_read & ~r_read_d & r_full[r_rd_bank];

    // FSM state and per-frame capture counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wcnt   <= '0;
            r_wtrunc <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_wcnt   <= w_cnt;
            r_wtrunc <= w_trunc;
        end
    end

    // Bank bookkeeping: commit fills the write bank, release empties the read bank
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
            r_trunc   <= 2'b00;
            r_read_d  <= 1'b0;
        end else begin
            r_read_d <= eth_rx_read;
            if (w_commit) begin
                r_full[r_wr_bank]  <= 1'b1;
                r_len[r_wr_bank]   <= w_cnt;
                r_trunc[r_wr_bank] <= w_trunc;
                r_wr_bank          <= ~r_wr_bank;
            end
            if (w_rel) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    // Frame RAM write port; contents intentionally not reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{r_wr_bank, w_waddr}] <= rx_data;
        end
    end

    // Registered CPU read port, refreshed every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_mem[{r_rd_bank, eth_rx_raddr}];
        end
    end

`ifdef ETH_RX_MBOX_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of dropped frames, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign eth_rx_ready = r_full[r_rd_bank];
    assign eth_rx_len   = r_len[r_rd_bank];
    assign eth_rx_trunc = r_trunc[r_rd_bank];
    assign eth_rx_rdata = r_rdata;
    assign o_dbg_state  = r_state;
    assign o_dbg_drop   = w_drop;

endmodule

// File: tb/tb_eth_rx_mailbox.sv
// Directed testbench for eth_rx_mailbox with hand-computed expectations.
module tb_eth_rx_mailbox;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;
  logic       eth_rx_ready;
  logic       eth_rx_read;
  logic [5:0] eth_rx_raddr;
  logic [7:0] eth_rx_rdata;
  logic [6:0] eth_rx_len;
  logic       eth_rx_trunc;
  logic [1:0] o_dbg_state;
  logic       o_dbg_drop;
`ifdef ETH_RX_MBOX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks;
  int failures;

  eth_rx_mailbox #(.DEPTH(64), .ADDR_W(6), .MIN_LEN(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_err       (rx_err),
    .eth_rx_ready (eth_rx_ready),
    .eth_rx_read  (eth_rx_read),
    .eth_rx_raddr (eth_rx_raddr),
    .eth_rx_rdata (eth_rx_rdata),
    .eth_rx_len   (eth_rx_len),
    .eth_rx_trunc (eth_rx_trunc),
`ifdef ETH_RX_MBOX_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .o_dbg_state  (o_dbg_state),
    .o_dbg_drop   (o_dbg_drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    rx_sof       = 1'b0;
    rx_eof       = 1'b0;
    rx_err       = 1'b0;
    eth_rx_read  = 1'b0;
    eth_rx_raddr = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof, input logic err);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_sof   = sof;
    rx_eof   = eof;
    rx_err   = err;
    step();
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_eof   = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] start, input logic err);
    for (int i = 0; i < len; i++) begin
      send_byte(start + 8'(i), i == 0, i == len - 1, err && (i == len - 1));
    end
  endtask

  task automatic read_byte(input logic [5:0] addr, output logic [7:0] d);
    eth_rx_raddr = addr;
    step();
    d = eth_rx_rdata;
  endtask

  task automatic pulse_read();
    eth_rx_read = 1'b1;
    step();
    eth_rx_read = 1'b0;
    step();
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (eth_rx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", eth_rx_ready); end
    checks++;
    if (eth_rx_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", eth_rx_rdata); end
    checks++;
    if (eth_rx_len !== 7'd0 || eth_rx_trunc !== 1'b0) begin
      failures++; $display("FAIL reset_len_trunc got=%0d/%b exp=0/0", eth_rx_len, eth_rx_trunc);
    end
    checks++;
    if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
`ifdef ETH_RX_MBOX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
  endtask

  task automatic test_basic_frame();
    logic [7:0] d;
    do_reset();
    send_frame(20, 8'h00, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd20 || eth_rx_trunc !== 1'b0) begin
      failures++; $display("FAIL basic_present got=%b/%0d/%b exp=1/20/0", eth_rx_ready, eth_rx_len, eth_rx_trunc);
    end
    read_byte(6'd5, d);
    checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL basic_rdata5 got=%h exp=05", d); end
    read_byte(6'd19, d);
    checks++;
    if (d !== 8'h13) begin failures++; $display("FAIL basic_rdata19 got=%h exp=13", d); end
    eth_rx_read = 1'b1;
    step();
    checks++;
    if (eth_rx_ready !== 1'b0) begin failures++; $display("FAIL basic_release got=%b exp=0", eth_rx_ready); end
    eth_rx_read = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    send_frame(20, 8'h40, 1'b0);
    send_frame(20, 8'h80, 1'b0);
    send_frame(20, 8'hC0, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", eth_rx_ready); end
    read_byte(6'd0, d);
    checks++;
    if (d !== 8'h40) begin failures++; $display("FAIL b2b_first got=%h exp=40", d); end
`ifdef ETH_RX_MBOX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin failures++; $display("FAIL b2b_drop_cnt got=%0d exp=1", drop_cnt); end
`endif
    pulse_read();
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd20) begin
      failures++; $display("FAIL b2b_second_ready got=%b/%0d exp=1/20", eth_rx_ready, eth_rx_len);
    end
    read_byte(6'd3, d);
    checks++;
    if (d !== 8'h83) begin failures++; $display("FAIL b2b_second_data got=%h exp=83", d); end
    pulse_read();
    checks++;
    if (eth_rx_ready !== 1'b0) begin failures++; $display("FAIL b2b_third_absent got=%b exp=0", eth_rx_ready); end
  endtask

  task automatic test_truncation();
    logic [7:0] d;
    do_reset();
    send_frame(100, 8'h00, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd64 || eth_rx_trunc !== 1'b1) begin
      failures++; $display("FAIL trunc_present got=%b/%0d/%b exp=1/64/1", eth_rx_ready, eth_rx_len, eth_rx_trunc);
    end
    read_byte(6'd63, d);
    checks++;
    if (d !== 8'h3F) begin failures++; $display("FAIL trunc_byte63 got=%h exp=3f", d); end
    read_byte(6'd0, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL trunc_byte0 got=%h exp=00", d); end
    read_byte(6'd36, d);
    checks++;
    if (d !== 8'h24) begin failures++; $display("FAIL trunc_byte36 got=%h exp=24", d); end
  endtask

  task automatic test_err_runt();
    logic [7:0] d;
    do_reset();
    send_frame(20, 8'h10, 1'b1);
    checks++;
    if (eth_rx_ready !== 1'b0) begin failures++; $display("FAIL err_ready got=%b exp=0", eth_rx_ready); end
    send_frame(10, 8'h20, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b0) begin failures++; $display("FAIL runt_ready got=%b exp=0", eth_rx_ready); end
`ifdef ETH_RX_MBOX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin failures++; $display("FAIL err_runt_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    send_frame(13, 8'h30, 1'b0);
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b0 || o_dbg_state !== 2'd0) begin
      failures++; $display("FAIL runt13_1byte got=%b/%0d exp=0/0", eth_rx_ready, o_dbg_state);
    end
    send_frame(14, 8'h60, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd14) begin
      failures++; $display("FAIL minlen_accept got=%b/%0d exp=1/14", eth_rx_ready, eth_rx_len);
    end
    read_byte(6'd13, d);
    checks++;
    if (d !== 8'h6D) begin failures++; $display("FAIL minlen_last got=%h exp=6d", d); end
`ifdef ETH_RX_MBOX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd4) begin failures++; $display("FAIL minlen_drop_cnt got=%0d exp=4", drop_cnt); end
`endif
  endtask

  task automatic test_hold_read();
    do_reset();
    send_frame(20, 8'h10, 1'b0);
    send_frame(30, 8'h50, 1'b0);
    eth_rx_read = 1'b1;
    step();
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd30) begin
      failures++; $display("FAIL hold_first_release got=%b/%0d exp=1/30", eth_rx_ready, eth_rx_len);
    end
    repeat (3) step();
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd30) begin
      failures++; $display("FAIL hold_no_rerelease got=%b/%0d exp=1/30", eth_rx_ready, eth_rx_len);
    end
    eth_rx_read = 1'b0;
    step();
    eth_rx_read = 1'b1;
    step();
    checks++;
    if (eth_rx_ready !== 1'b0) begin failures++; $display("FAIL hold_second_release got=%b exp=0", eth_rx_ready); end
    eth_rx_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] d;
    do_reset();
    send_byte(8'hE0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_dbg_state !== 2'd1) begin failures++; $display("FAIL mid_capture_state got=%0d exp=1", o_dbg_state); end
    do_reset();
    for (int i = 5; i < 20; i++) send_byte(8'hE0 + 8'(i), 1'b0, i == 19, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b0 || o_dbg_state !== 2'd0) begin
      failures++; $display("FAIL tail_ignored got=%b/%0d exp=0/0", eth_rx_ready, o_dbg_state);
    end
    send_frame(20, 8'hA0, 1'b0);
    checks++;
    if (eth_rx_ready !== 1'b1 || eth_rx_len !== 7'd20) begin
      failures++; $display("FAIL after_reset_frame got=%b/%0d exp=1/20", eth_rx_ready, eth_rx_len);
    end
    read_byte(6'd4, d);
    checks++;
    if (d !== 8'hA4) begin failures++; $display("FAIL after_reset_data got=%h exp=a4", d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_truncation();
    test_err_runt();
    test_hold_read();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
